// File: rtl/relu_maxpool2x2_pkg.sv
// Shared constants for the LeNet-style conv -> ReLU -> 2x2 maxpool pipeline.
// The MAC array, this block and the next layer's input all read the
// geometry and the activation width from here, so every stage agrees on them.
package relu_maxpool2x2_pkg;

    // Datapath widths
    localparam int CONV_BW  = 20;   // convolution sum / bias width
    localparam int ACT_BW   = 8;    // signed activation width (values kept >= 0)

    // Layer 1: 28x28 input, 5x5 conv -> 24x24, pooled to 12x12
    localparam int L1_IMG_W = 24;
    localparam int L1_IMG_H = 24;
    localparam int L1_SHIFT = 4;

    // Layer 2: 12x12 input, 5x5 conv -> 8x8, pooled to 4x4
    localparam int L2_IMG_W = 8;
    localparam int L2_IMG_H = 8;
    localparam int L2_SHIFT = 4;

    // Pooling action selected by the parity of the pixel's row/col tag
    typedef enum logic [1:0] {
        POOL_HOLD_TOP = 2'b00,  // even row, even col: hold left pixel
        POOL_WR_LB    = 2'b01,  // even row, odd col : store top-pair max
        POOL_HOLD_BOT = 2'b10,  // odd row,  even col: hold left pixel
        POOL_EMIT     = 2'b11   // odd row,  odd col : close the window
    } pool_op_e;

    function automatic pool_op_e pool_op(input logic row_odd, input logic col_odd);
        pool_op_e op;
        case ({row_odd, col_odd})
            2'b00:   op = POOL_HOLD_TOP;
            2'b01:   op = POOL_WR_LB;
            2'b10:   op = POOL_HOLD_BOT;
            2'b11:   op = POOL_EMIT;
            default: op = POOL_HOLD_TOP;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/relu_maxpool2x2_pool_line_buf.sv
// Line buffer for the pooling stage: holds the max of each top-row pixel
// pair of the current window row until the matching bottom row arrives.
// Storage is not reset; an even row always writes an entry before the
// following odd row reads it.
module pool_line_buf #(
    parameter int DEPTH = 12,
    parameter int DW    = 8,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [DW-1:0] i_wr_data,
    input  logic [AW-1:0] i_rd_addr,
    output logic [DW-1:0] o_rd_data
);

    logic [DW-1:0] r_mem [DEPTH];

    // Single write port, no reset on the storage array
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/relu_maxpool2x2.sv
// Post-convolution stage for one output channel: bias add, ReLU,
// requantize with saturation, then 2x2 stride-2 max pooling over a
// raster-ordered pixel stream. Two register stages: the output pulse
// appears two clocks after the window's closing pixel.
module relu_maxpool2x2
    import relu_maxpool2x2_pkg::*;
#(
    parameter int O_CONV_BW = CONV_BW,
    parameter int O_BW      = ACT_BW,
    parameter int SHIFT     = L1_SHIFT,
    parameter int IMG_W     = L1_IMG_W,
    parameter int IMG_H     = L1_IMG_H
) (
    input  logic                 clk,
    input  logic                 global_rst_n,
    input  logic                 rst,
    input  logic                 i_valid,
    input  logic [O_CONV_BW-1:0] i_data,
    input  logic [O_CONV_BW-1:0] i_bias,
    output logic                 o_valid,
    output logic [O_BW-1:0]      o_data,
    output logic                 o_frame_done
);

    localparam int SW       = O_CONV_BW + 1;
    localparam int CW       = (IMG_W > 2) ? $clog2(IMG_W) : 1;
    localparam int RW       = (IMG_H > 2) ? $clog2(IMG_H) : 1;
    localparam int LB_DEPTH = IMG_W / 2;
    localparam int AW       = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

    localparam logic [CW-1:0]        COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0]        ROW_LAST = RW'(IMG_H - 1);
    localparam logic signed [SW-1:0] Q_MAX    = SW'((1 << (O_BW - 1)) - 1);

    // Pixel position counters
    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;

    // Stage-1 registers: requantized pixel plus its position tag
    logic            r_s1_valid;
    logic [O_BW-1:0] r_s1_q;
    logic            r_s1_row_odd;
    logic            r_s1_col_odd;
    logic [AW-1:0]   r_s1_addr;
    logic            r_s1_last;

    // Stage-2 state: left pixel of the current pair
    logic [O_BW-1:0] r_h;

    logic signed [SW-1:0] w_sum;
    logic signed [SW-1:0] w_relu;
    logic signed [SW-1:0] w_shr;
    logic [O_BW-1:0]      w_q;
    logic [O_BW-1:0]      w_max_hq;
    logic [O_BW-1:0]      w_max3;
    logic [O_BW-1:0]      w_lb_rd;
    logic                 w_lb_wr_en;
    pool_op_e             w_op;

    // Bias add at one extra bit, ReLU, requantize shift and saturation
    always_comb begin
        w_sum = $signed({i_data[O_CONV_BW-1], i_data}) + $signed({i_bias[O_CONV_BW-1], i_bias});
        if (w_sum < $signed({SW{1'b0}})) begin
            w_relu = {SW{1'b0}};
        end else begin
            w_relu = w_sum;
        end
        w_shr = w_relu >>> SHIFT;
        if (w_shr > Q_MAX) begin
            w_q = Q_MAX[O_BW-1:0];
        end else begin
            w_q = w_shr[O_BW-1:0];
        end
    end

    // Column/row counters advance on valid pixels and wrap at frame end
    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n) begin
            r_col <= '0;
            r_row <= '0;
        end else if (rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (i_valid) begin
            if (r_col == COL_LAST) begin
                r_col <= '0;
                if (r_row == ROW_LAST) begin
                    r_row <= '0;
                end else begin
                    r_row <= r_row + RW'(1);
                end
            end else begin
                r_col <= r_col + CW'(1);
            end
        end
    end

    // Stage 1: register requantized pixel with its position tag
    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n) begin
            r_s1_valid   <= 1'b0;
            r_s1_q       <= '0;
            r_s1_row_odd <= 1'b0;
            r_s1_col_odd <= 1'b0;
            r_s1_addr    <= '0;
            r_s1_last    <= 1'b0;
        end else if (rst) begin
            r_s1_valid   <= 1'b0;
            r_s1_q       <= '0;
            r_s1_row_odd <= 1'b0;
            r_s1_col_odd <= 1'b0;
            r_s1_addr    <= '0;
            r_s1_last    <= 1'b0;
        end else begin
            r_s1_valid <= i_valid;
            if (i_valid) begin
                r_s1_q       <= w_q;
                r_s1_row_odd <= r_row[0];
                r_s1_col_odd <= r_col[0];
                r_s1_addr    <= AW'(r_col >> 1);
                r_s1_last    <= (r_col == COL_LAST) && (r_row == ROW_LAST);
            end
        end
    end

    // Pooling decisions and maxima (values are non-negative, compared signed)
    always_comb begin
        w_op       = pool_op(r_s1_row_odd, r_s1_col_odd);
        w_lb_wr_en = r_s1_valid && (w_op == POOL_WR_LB);
        if ($signed(r_s1_q) > $signed(r_h)) begin
            w_max_hq = r_s1_q;
        end else begin
            w_max_hq = r_h;
        end
        if ($signed(w_lb_rd) > $signed(w_max_hq)) begin
            w_max3 = w_lb_rd;
        end else begin
            w_max3 = w_max_hq;
        end
    end

    pool_line_buf #(
        .DEPTH (LB_DEPTH),
        .DW    (O_BW),
        .AW    (AW)
    ) u_line_buf (
        .clk       (clk),
        .i_wr_en   (w_lb_wr_en),
        .i_wr_addr (r_s1_addr),
        .i_wr_data (w_max_hq),
        .i_rd_addr (r_s1_addr),
        .o_rd_data (w_lb_rd)
    );

    // Stage 2: hold left pixels, close windows and drive registered outputs
    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n) begin
            r_h          <= '0;
            o_valid      <= 1'b0;
            o_data       <= '0;
            o_frame_done <= 1'b0;
        end else if (rst) begin
            r_h          <= '0;
            o_valid      <= 1'b0;
            o_data       <= '0;
            o_frame_done <= 1'b0;
        end else begin
            o_valid      <= 1'b0;
            o_frame_done <= 1'b0;
            if (r_s1_valid) begin
                case (w_op)
                    POOL_HOLD_TOP: r_h <= r_s1_q;
                    POOL_HOLD_BOT: r_h <= r_s1_q;
                    POOL_WR_LB:    r_h <= r_h;
                    POOL_EMIT: begin
                        o_data       <= w_max3;
                        o_valid      <= 1'b1;
                        o_frame_done <= r_s1_last;
                    end
                    default:       r_h <= r_h;
                endcase
            end
        end
    end

endmodule
